// File: rtl/wb_pkg.sv
// Shared types and default widths for the register-file writeback port arbiter.
package wb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {MEM_PRI, ALU_FORCE} wb_grant_e;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Producer handshakes, RF write port and hazard outputs of the writeback arbiter.
interface wb_port_arbiter_if #(
  parameter int unsigned DATA_W = wb_pkg::DATA_W,
  parameter int unsigned ADDR_W = wb_pkg::ADDR_W
) ();

  logic                      alu_valid;
  logic                      alu_ready;
  logic [ADDR_W-1:0]         alu_addr;
  logic [DATA_W-1:0]         alu_data;
  logic                      mem_valid;
  logic                      mem_ready;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_data;
  logic                      rfWriteEn_p0;
  logic [ADDR_W-1:0]         rfWriteAddr_p0;
  logic [DATA_W-1:0]         rfWriteData_p0;
  logic [(1<<ADDR_W)-1:0]    pend_mask;
  logic                      busy;

  // Producers / register file side.
  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    input  alu_ready, mem_ready, rfWriteEn_p0, rfWriteAddr_p0, rfWriteData_p0, pend_mask, busy
  );

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    output alu_ready, mem_ready, rfWriteEn_p0, rfWriteAddr_p0, rfWriteData_p0, pend_mask, busy
  );

endinterface

// File: rtl/wb_req_fifo.sv
// Small in-order request buffer; exposes per-slot valid/address for hazard masking.
module wb_req_fifo #(
  parameter int unsigned AddrW = 5,
  parameter int unsigned DataW = 32,
  parameter int unsigned Depth = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        push_valid_i,
  output logic                        push_ready_o,
  input  logic [AddrW-1:0]            push_addr_i,
  input  logic [DataW-1:0]            push_data_i,
  output logic                        head_valid_o,
  output logic [AddrW-1:0]            head_addr_o,
  output logic [DataW-1:0]            head_data_o,
  input  logic                        pop_i,
  output logic [Depth-1:0]            slot_valid_o,
  output logic [Depth-1:0][AddrW-1:0] slot_addr_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [PtrW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [Depth-1:0]           vld_q, vld_d;
  logic [Depth-1:0][AddrW-1:0] addr_q;
  logic [Depth-1:0][DataW-1:0] data_q;
  logic                       push;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready depends on occupancy only: a full buffer refuses even while popping.
  assign push_ready_o = ~&vld_q;
  assign push         = push_valid_i & push_ready_o;
  assign head_valid_o = vld_q[rd_ptr_q];
  assign head_addr_o  = addr_q[rd_ptr_q];
  assign head_data_o  = data_q[rd_ptr_q];
  assign slot_valid_o = vld_q;
  assign slot_addr_o  = addr_q;

  always_comb begin
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (pop_i && head_valid_o) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = ptr_inc(rd_ptr_q);
    end
    if (push) begin
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) begin
        addr_q[wr_ptr_q] <= push_addr_i;
        data_q[wr_ptr_q] <= push_data_i;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates ALU writeback and load-return writes onto one RF write port:
// memory first, with the ALU forced through after STARVE_MAX consecutive losses.
module wb_port_arbiter #(
  parameter int unsigned DATA_W     = wb_pkg::DATA_W,
  parameter int unsigned ADDR_W     = wb_pkg::ADDR_W,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_port_arbiter_if.slave  wb_io
);

  import wb_pkg::*;

  localparam int unsigned StarveW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  logic                             mem_hv, alu_hv;
  logic [ADDR_W-1:0]                mem_haddr, alu_haddr;
  logic [DATA_W-1:0]                mem_hdata, alu_hdata;
  logic [FIFO_DEPTH-1:0]            mem_slot_vld, alu_slot_vld;
  logic [FIFO_DEPTH-1:0][ADDR_W-1:0] mem_slot_addr, alu_slot_addr;
  logic                             grant_mem, grant_alu;

  wb_grant_e            state_q, state_d;
  logic [StarveW-1:0]   starve_q, starve_d;
  logic                 wr_en_q;
  logic [ADDR_W-1:0]    wr_addr_q;
  logic [DATA_W-1:0]    wr_data_q;
  logic [(1<<ADDR_W)-1:0] pend_mask;

  // Writes to r0 complete the handshake but are dropped before the buffer.
  wb_req_fifo #(
    .AddrW (ADDR_W),
    .DataW (DATA_W),
    .Depth (FIFO_DEPTH)
  ) u_mem_fifo (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .push_valid_i (wb_io.mem_valid && (wb_io.mem_addr != '0)),
    .push_ready_o (wb_io.mem_ready),
    .push_addr_i  (wb_io.mem_addr),
    .push_data_i  (wb_io.mem_data),
    .head_valid_o (mem_hv),
    .head_addr_o  (mem_haddr),
    .head_data_o  (mem_hdata),
    .pop_i        (grant_mem),
    .slot_valid_o (mem_slot_vld),
    .slot_addr_o  (mem_slot_addr)
  );

  wb_req_fifo #(
    .AddrW (ADDR_W),
    .DataW (DATA_W),
    .Depth (FIFO_DEPTH)
  ) u_alu_fifo (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .push_valid_i (wb_io.alu_valid && (wb_io.alu_addr != '0)),
    .push_ready_o (wb_io.alu_ready),
    .push_addr_i  (wb_io.alu_addr),
    .push_data_i  (wb_io.alu_data),
    .head_valid_o (alu_hv),
    .head_addr_o  (alu_haddr),
    .head_data_o  (alu_hdata),
    .pop_i        (grant_alu),
    .slot_valid_o (alu_slot_vld),
    .slot_addr_o  (alu_slot_addr)
  );

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    grant_mem = 1'b0;
    grant_alu = 1'b0;
    case (state_q)
      MEM_PRI: begin
        if (mem_hv) begin
          grant_mem = 1'b1;
        end else if (alu_hv) begin
          grant_alu = 1'b1;
        end
        if (alu_hv && !grant_alu) begin
          starve_d = starve_q + 1'b1;
          if (starve_d >= StarveW'(STARVE_MAX)) state_d = ALU_FORCE;
        end else begin
          starve_d = '0;
        end
      end
      ALU_FORCE: begin
        // ALU head is always present here; the memory fallback only guards corner cases.
        if (alu_hv) begin
          grant_alu = 1'b1;
        end else if (mem_hv) begin
          grant_mem = 1'b1;
        end
        starve_d = '0;
        state_d  = MEM_PRI;
      end
      default: state_d = MEM_PRI;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MEM_PRI;
      starve_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      wr_en_q  <= grant_mem | grant_alu;
      if (grant_mem) begin
        wr_addr_q <= mem_haddr;
        wr_data_q <= mem_hdata;
      end else if (grant_alu) begin
        wr_addr_q <= alu_haddr;
        wr_data_q <= alu_hdata;
      end
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (mem_slot_vld[i]) pend_mask[mem_slot_addr[i]] = 1'b1;
      if (alu_slot_vld[i]) pend_mask[alu_slot_addr[i]] = 1'b1;
    end
  end

  assign wb_io.rfWriteEn_p0   = wr_en_q;
  assign wb_io.rfWriteAddr_p0 = wr_addr_q;
  assign wb_io.rfWriteData_p0 = wr_data_q;
  assign wb_io.pend_mask      = pend_mask;
  assign wb_io.busy           = (|mem_slot_vld) | (|alu_slot_vld);

endmodule
